// File: rtl/memory_arbiter.sv
// Two-port memory arbiter: the instruction cache (port 0) and the data cache (port 1)
// share one line-wide memory. The winner holds ownership until it pulses req_done.
module memory_arbiter #(
    parameter int CACHE_LINE_SIZE     = 128,
    parameter int MEMORY_ADDRESS_SIZE = 32
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic                           req_init_0,
    input  logic                           req_start_0,
    input  logic                           req_done_0,
    input  logic [MEMORY_ADDRESS_SIZE-1:0] req_address_0,
    input  logic                           req_op_0,
    input  logic [CACHE_LINE_SIZE-1:0]     req_data_0,
    output logic                           allow_op_0,
    output logic                           data_ready_0,
    output logic [CACHE_LINE_SIZE-1:0]     data_out_0,

    input  logic                           req_init_1,
    input  logic                           req_start_1,
    input  logic                           req_done_1,
    input  logic [MEMORY_ADDRESS_SIZE-1:0] req_address_1,
    input  logic                           req_op_1,
    input  logic [CACHE_LINE_SIZE-1:0]     req_data_1,
    output logic                           allow_op_1,
    output logic                           data_ready_1,
    output logic [CACHE_LINE_SIZE-1:0]     data_out_1,

    output logic                           mem_enable,
    output logic                           mem_op,
    output logic [MEMORY_ADDRESS_SIZE-1:0] mem_address,
    output logic [CACHE_LINE_SIZE-1:0]     mem_data_in,
    input  logic                           mem_data_ready,
    input  logic [CACHE_LINE_SIZE-1:0]     mem_data_out
);

    typedef enum logic [1:0] {IDLE, GRANT, ACCESS, RESPOND} state_t;

    state_t                         state;
    logic                           owner;
    logic                           last_grant;
    logic                           pick;
    logic [1:0]                     init, start, done, op;
    logic [MEMORY_ADDRESS_SIZE-1:0] address [2];
    logic [CACHE_LINE_SIZE-1:0]     line    [2];
    logic [1:0]                     allow_q, ready_q;
    logic [CACHE_LINE_SIZE-1:0]     rdata_q [2];

    assign init       = {req_init_1,  req_init_0};
    assign start      = {req_start_1, req_start_0};
    assign done       = {req_done_1,  req_done_0};
    assign op         = {req_op_1,    req_op_0};
    assign address[0] = req_address_0;
    assign address[1] = req_address_1;
    assign line[0]    = req_data_0;
    assign line[1]    = req_data_1;

    // On contention the port that was not served last wins.
    assign pick = (init == 2'b11) ? ~last_grant : init[1];

    assign allow_op_0   = allow_q[0];
    assign allow_op_1   = allow_q[1];
    assign data_ready_0 = ready_q[0];
    assign data_ready_1 = ready_q[1];
    assign data_out_0   = rdata_q[0];
    assign data_out_1   = rdata_q[1];

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b0;
            allow_q     <= '0;
            ready_q     <= '0;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
            mem_enable  <= 1'b0;
            mem_op      <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
        end else begin
            mem_enable <= 1'b0;
            if (state != IDLE && done[owner]) begin
                allow_q    <= '0;
                ready_q    <= '0;
                last_grant <= owner;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (|init) begin
                            owner   <= pick;
                            allow_q <= pick ? 2'b10 : 2'b01;
                            state   <= GRANT;
                        end
                    end
                    GRANT: begin
                        if (start[owner]) begin
                            mem_address <= address[owner];
                            mem_op      <= op[owner];
                            mem_data_in <= line[owner];
                            mem_enable  <= 1'b1;
                            state       <= ACCESS;
                        end else if (!init[owner]) begin
                            allow_q <= '0;
                            state   <= IDLE;
                        end
                    end
                    ACCESS: begin
                        if (mem_data_ready) begin
                            if (!mem_op) begin
                                rdata_q[owner] <= mem_data_out;
                            end
                            ready_q[owner] <= 1'b1;
                            state          <= RESPOND;
                        end
                    end
                    RESPOND: begin
                        // Dropping start keeps ownership so a writeback can chain into a refill.
                        if (!start[owner]) begin
                            ready_q <= '0;
                            state   <= GRANT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized
// transactions checked against a behavioural memory and arbitration model.
module tb_memory_arbiter;

    localparam int L = 128;
    localparam int A = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    init, start, done, op_r;
    logic [A-1:0]  addr [2];
    logic [L-1:0]  wd   [2];
    logic [1:0]    allow, ready;
    logic [L-1:0]  dout0, dout1;
    logic          mem_enable, mem_op, mem_data_ready;
    logic [A-1:0]  mem_address;
    logic [L-1:0]  mem_data_in, mem_data_out;

    always #5 clk = ~clk;

    memory_arbiter #(.CACHE_LINE_SIZE(L), .MEMORY_ADDRESS_SIZE(A)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_init_0    (init[0]),
        .req_start_0   (start[0]),
        .req_done_0    (done[0]),
        .req_address_0 (addr[0]),
        .req_op_0      (op_r[0]),
        .req_data_0    (wd[0]),
        .allow_op_0    (allow[0]),
        .data_ready_0  (ready[0]),
        .data_out_0    (dout0),
        .req_init_1    (init[1]),
        .req_start_1   (start[1]),
        .req_done_1    (done[1]),
        .req_address_1 (addr[1]),
        .req_op_1      (op_r[1]),
        .req_data_1    (wd[1]),
        .allow_op_1    (allow[1]),
        .data_ready_1  (ready[1]),
        .data_out_1    (dout1),
        .mem_enable    (mem_enable),
        .mem_op        (mem_op),
        .mem_address   (mem_address),
        .mem_data_in   (mem_data_in),
        .mem_data_ready(mem_data_ready),
        .mem_data_out  (mem_data_out)
    );

    // Reference model: memory contents, last line read per port, last served port.
    logic [L-1:0] model_mem [logic [A-1:0]];
    logic [L-1:0] exp_dout  [2];
    int           prev_winner;
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [A-1:0] addrs [4] = '{32'h40, 32'h80, 32'h100, 32'h200};

    function automatic logic [L-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [L-1:0] mem_read(input logic [A-1:0] a);
        if (!model_mem.exists(a)) model_mem[a] = rand_line();
        return model_mem[a];
    endfunction

    function automatic logic [1:0] onehot(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [L-1:0] dout_of(input int p);
        return (p == 1) ? dout1 : dout0;
    endfunction

    // Advance one cycle; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        n_checks++;
        if (allow === 2'b11) $display("FAIL mutex: allow_op=%b, required at most one high", allow);
        else n_pass++;
    endtask

    task automatic clear_inputs();
        init = '0; start = '0; done = '0; op_r = '0;
        addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
        mem_data_ready = 1'b0; mem_data_out = '0;
    endtask

    task automatic model_reset();
        prev_winner = 0;
        exp_dout[0] = '0;
        exp_dout[1] = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({allow, ready, mem_enable, mem_op} !== 6'b0)
            $display("FAIL %s_ctrl: allow=%b ready=%b en=%b op=%b, required all 0", tag, allow, ready, mem_enable, mem_op);
        else n_pass++;
        n_checks++;
        if (mem_address !== '0 || mem_data_in !== '0)
            $display("FAIL %s_mem: addr=%h din=%h, required 0", tag, mem_address, mem_data_in);
        else n_pass++;
        n_checks++;
        if (dout0 !== '0 || dout1 !== '0)
            $display("FAIL %s_dout: dout0=%h dout1=%h, required 0", tag, dout0, dout1);
        else n_pass++;
    endtask

    task automatic check_grant(input string tag, input logic [1:0] exp);
        n_checks++;
        if (allow !== exp) $display("FAIL %s: allow_op=%b, required %b", tag, allow, exp);
        else n_pass++;
    endtask

    // One memory access by port p, which must already own the arbiter.
    task automatic run_access(input int p, input logic op, input logic [A-1:0] a, input int lat);
        logic [L-1:0] w;
        w = rand_line();
        addr[p] = a; op_r[p] = op; wd[p] = w; start[p] = 1'b1;
        tick();
        n_checks++;
        if ({mem_enable, mem_op, mem_address} !== {1'b1, op, a})
            $display("FAIL mem_start: en=%b op=%b addr=%h, required 1 %b %h", mem_enable, mem_op, mem_address, op, a);
        else n_pass++;
        n_checks++;
        if (mem_data_in !== w) $display("FAIL mem_data_in: got %h, required %h", mem_data_in, w);
        else n_pass++;
        addr[p] = $urandom; op_r[p] = ~op; wd[p] = rand_line();
        for (int i = 0; i < lat; i++) begin
            tick();
            n_checks++;
            if ({mem_enable, mem_op, mem_address, mem_data_in, ready, allow} !== {1'b0, op, a, w, 2'b00, onehot(p)})
                $display("FAIL mem_hold: en=%b op=%b addr=%h ready=%b allow=%b, required 0 %b %h 00 %b",
                         mem_enable, mem_op, mem_address, ready, allow, op, a, onehot(p));
            else n_pass++;
        end
        mem_data_ready = 1'b1;
        if (op) begin
            mem_data_out = rand_line();
            model_mem[a] = w;
        end else begin
            mem_data_out = mem_read(mem_address);
            exp_dout[p]  = mem_read(a);
        end
        tick();
        mem_data_ready = 1'b0;
        mem_data_out   = rand_line();
        n_checks++;
        if (ready !== onehot(p)) $display("FAIL data_ready: got %b, required %b", ready, onehot(p));
        else n_pass++;
        n_checks++;
        if (dout_of(p) !== exp_dout[p]) $display("FAIL data_out: got %h, required %h", dout_of(p), exp_dout[p]);
        else n_pass++;
        n_checks++;
        if (dout_of(1 - p) !== exp_dout[1 - p])
            $display("FAIL data_out_other: got %h, required %h", dout_of(1 - p), exp_dout[1 - p]);
        else n_pass++;
        tick();
        n_checks++;
        if (ready !== onehot(p)) $display("FAIL ready_hold: got %b, required %b", ready, onehot(p));
        else n_pass++;
    endtask

    task automatic chain_next(input int p);
        start[p] = 1'b0;
        tick();
        n_checks++;
        if (ready !== 2'b00 || allow !== onehot(p))
            $display("FAIL chain: ready=%b allow=%b, required 00 %b", ready, allow, onehot(p));
        else n_pass++;
    endtask

    task automatic release_port(input int p);
        done[p] = 1'b1; start[p] = 1'b0; init[p] = 1'b0;
        tick();
        done[p] = 1'b0;
        n_checks++;
        if (allow !== 2'b00 || ready !== 2'b00)
            $display("FAIL release: allow=%b ready=%b, required 00 00", allow, ready);
        else n_pass++;
        prev_winner = p;
    endtask

    task automatic test_reset();
        do_reset();
        check_all_zero("reset");
    endtask

    task automatic test_read_port0();
        do_reset();
        model_mem[32'h40] = 128'h0123456789abcdef0123456789abcdef;
        init[0] = 1'b1;
        tick();
        check_grant("grant_0", 2'b01);
        run_access(0, 1'b0, 32'h40, 3);
        tick();
        n_checks++;
        if (ready !== 2'b01 || dout0 !== 128'h0123456789abcdef0123456789abcdef)
            $display("FAIL read0_hold: ready=%b dout0=%h, required 01 0123456789abcdef0123456789abcdef", ready, dout0);
        else n_pass++;
        release_port(0);
    endtask

    task automatic test_arbitration();
        do_reset();
        init = 2'b11;
        tick();
        check_grant("first_grant", 2'b10);
        run_access(1, 1'b0, addrs[$urandom_range(0, 3)], 2);
        release_port(1);
        tick();
        check_grant("second_grant", 2'b01);
        release_port(0);
    endtask

    task automatic test_writeback_chain();
        do_reset();
        init[1] = 1'b1;
        tick();
        check_grant("wb_grant", 2'b10);
        init[0] = 1'b1;
        run_access(1, 1'b1, 32'h100, 2);
        chain_next(1);
        run_access(1, 1'b0, 32'h200, 2);
        release_port(1);
        tick();
        check_grant("wb_pending", 2'b01);
        release_port(0);
    endtask

    task automatic test_abandon();
        do_reset();
        init[0] = 1'b1;
        tick();
        check_grant("abandon_grant", 2'b01);
        init[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (allow !== 2'b00 || mem_enable !== 1'b0)
                $display("FAIL abandon: allow=%b en=%b, required 00 0", allow, mem_enable);
            else n_pass++;
        end
    endtask

    task automatic test_reset_in_access();
        do_reset();
        init[0] = 1'b1;
        tick();
        addr[0] = 32'h80; op_r[0] = 1'b0; wd[0] = rand_line(); start[0] = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
        model_reset();
        check_all_zero("abort");
        mem_data_ready = 1'b1;
        mem_data_out   = rand_line();
        tick();
        mem_data_ready = 1'b0;
        check_all_zero("abort_late");
        init[1] = 1'b1;
        tick();
        check_grant("abort_idle", 2'b10);
        release_port(1);
    endtask

    task automatic test_spurious_ready();
        do_reset();
        init[0] = 1'b1;
        tick();
        run_access(0, 1'b0, 32'h40, 1);
        release_port(0);
        mem_data_ready = 1'b1;
        mem_data_out   = rand_line();
        tick();
        mem_data_ready = 1'b0;
        n_checks++;
        if (dout0 !== exp_dout[0] || {allow, ready, mem_enable} !== 5'b0)
            $display("FAIL spurious: dout0=%h allow=%b ready=%b en=%b, required %h 00 00 0",
                     dout0, allow, ready, mem_enable, exp_dout[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0] pend;
        int         w, n;
        do_reset();
        pend = 2'b00;
        for (int it = 0; it < 30; it++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 1) == 1) pend[p] = 1'b1;
            if (pend == 2'b00) pend[$urandom_range(0, 1)] = 1'b1;
            init = pend;
            w = (pend == 2'b11) ? 1 - prev_winner : (pend[1] ? 1 : 0);
            tick();
            check_grant("rand_grant", onehot(w));
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                if (k > 0) chain_next(w);
                run_access(w, 1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)], $urandom_range(1, 4));
            end
            release_port(w);
            pend[w] = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_read_port0();
        test_arbitration();
        test_writeback_chain();
        test_abandon();
        test_reset_in_access();
        test_spurious_ready();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameters SHALL be: CACHE_LINE_SIZE, 128, line width in bits; MEMORY_ADDRESS_SIZE, 32, address width; both SHALL be taken from the shared parameters include.
REQ-002 clk  in  1  single clock; all state SHALL change on the rising edge only.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Requester ports SHALL be indexed 0 = instruction cache, 1 = data cache; each requester n SHALL have the signals in REQ-005..REQ-010.
REQ-005 req_init_n  in  1  request memory ownership (cache mem_op_init).
REQ-006 req_start_n  in  1  operands valid, start the access (cache start_access).
REQ-007 req_done_n  in  1  one-cycle pulse releasing ownership (cache mem_op_done).
REQ-008 req_address_n  in  MEMORY_ADDRESS_SIZE  line address; req_op_n  in  1  0 = read, 1 = write; req_data_n  in  CACHE_LINE_SIZE  write line.
REQ-009 allow_op_n  out  1  ownership granted to requester n.
REQ-010 data_ready_n  out  1  access complete; data_out_n  out  CACHE_LINE_SIZE  read line.
REQ-011 Memory-side ports SHALL be: mem_enable out 1 (one-cycle start pulse); mem_op out 1; mem_address out MEMORY_ADDRESS_SIZE; mem_data_in out CACHE_LINE_SIZE; mem_data_ready in 1 (memory completion); mem_data_out in CACHE_LINE_SIZE.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, GRANT, ACCESS, RESPOND; all outputs SHALL be registered.
REQ-013 In IDLE with one req_init asserted, that requester SHALL win; the FSM SHALL enter GRANT and assert its allow_op_n on the next edge.
REQ-014 In IDLE with both req_init asserted, the requester not granted last SHALL win; the last-grant bit after reset SHALL select port 1 (data cache) first.
REQ-015 At most one allow_op_n SHALL be high in any cycle.
REQ-016 In GRANT with the winner's req_start_n high, the arbiter SHALL latch address, op and data to mem_address/mem_op/mem_data_in, pulse mem_enable for exactly one cycle, and enter ACCESS.
REQ-017 In GRANT with the winner's req_init_n low and req_start_n low, the arbiter SHALL drop allow_op_n and return to IDLE (abandoned request).
REQ-018 In ACCESS, the arbiter SHALL hold mem_address/mem_op/mem_data_in stable until mem_data_ready is seen.
REQ-019 On mem_data_ready in ACCESS: for a read, mem_data_out SHALL be captured into data_out_n; data_ready_n SHALL be set; the FSM SHALL enter RESPOND.
REQ-020 A write SHALL leave data_out_n unchanged.
REQ-021 In RESPOND, data_ready_n SHALL stay high until the winner raises req_done_n or drops req_start_n.
REQ-022 req_done_n in RESPOND (or in any granted state) SHALL clear data_ready_n and allow_op_n, update last-grant, and go to IDLE.
REQ-023 req_start_n dropping in RESPOND without req_done_n SHALL clear data_ready_n, keep allow_op_n, and return to GRANT; this lets a dirty-line writeback chain into a refill without re-arbitration.
REQ-024 mem_data_ready outside ACCESS SHALL be ignored; the other requester's outputs SHALL remain 0 throughout a transaction.
REQ-025 A grant to port 0 and a subsequent request on port 1 SHALL be serviced only after port 0 releases, with port 1 granted in the cycle after the release.
REQ-026 The latency from GRANT start to mem_enable SHALL be 1 cycle; the latency from mem_data_ready to data_ready_n SHALL be 1 cycle.

Reset
REQ-027 On reset the FSM SHALL enter IDLE and the last-grant bit SHALL select port 1 first.
REQ-028 On reset, allow_op_n, data_ready_n, mem_enable, mem_op, mem_address, mem_data_in and data_out_n SHALL all be 0.
REQ-029 Reset during ACCESS or RESPOND SHALL abort the transaction, and a subsequent mem_data_ready SHALL be ignored.

Verification
REQ-030 Read port 0, address 0x00000040, memory returns 0x0123..EF after 3 cycles -> allow_op_0 high, one mem_enable pulse with mem_op=0 and address 0x40, data_out_0 = line, data_ready_0 high until done.
REQ-031 Both req_init high out of reset -> port 1 granted first; after req_done_1, port 0 granted on the next IDLE->GRANT; allow_op never high on both ports.
REQ-032 Port 1 writeback (op=1, address 0x100) then drop start, re-raise start with read 0x200 -> two mem_enable pulses, allow_op_1 continuously high, no grant to pending port 0 until done.
REQ-033 req_init_0 pulsed then dropped before req_start_0 -> return to IDLE with no mem_enable pulse.
REQ-034 Reset asserted in ACCESS, then mem_data_ready arrives -> all outputs 0, data_ready_n stays 0, FSM in IDLE.
REQ-035 Spurious mem_data_ready in IDLE -> no output change.
